// File: rtl/median_ctrl_pkg.sv
// Shared types and helpers for the median filter frame controller.
// Sizes follow the frame/window parameters of the instantiating block.
package median_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_e;

   // Number of full KxK windows in a ROWS x COLS frame.
   function automatic int out_total(input int rows, input int cols, input int k);
      return (rows - k + 1) * (cols - k + 1);
   endfunction

   // Distance from a window origin to its centre pixel.
   function automatic int win_off(input int k);
      return (k - 1) / 2;
   endfunction

endpackage

// File: rtl/median_frame_ctrl_raster_counter.sv
// Raster-order column/row counter with clear, enable and end-of-frame flag.
// The *_nxt outputs expose the value the counter takes at the next edge.
module raster_counter #(
   parameter int W = 8,
   parameter int H = 8
) (
   input  logic                                  clk,
   input  logic                                  rst,
   input  logic                                  clr_i,
   input  logic                                  en_i,
   output logic [((W > 1) ? $clog2(W) : 1)-1:0]  col_o,
   output logic [((H > 1) ? $clog2(H) : 1)-1:0]  row_o,
   output logic [((W > 1) ? $clog2(W) : 1)-1:0]  col_nxt_o,
   output logic [((H > 1) ? $clog2(H) : 1)-1:0]  row_nxt_o,
   output logic                                  last_o
);
   localparam int CW = (W > 1) ? $clog2(W) : 1;
   localparam int RW = (H > 1) ? $clog2(H) : 1;
   localparam logic [CW-1:0] COL_MAX = CW'(W - 1);
   localparam logic [RW-1:0] ROW_MAX = RW'(H - 1);

   logic [CW-1:0] col_q, col_d;
   logic [RW-1:0] row_q, row_d;

   always_comb begin
      col_d = col_q;
      row_d = row_q;
      if (clr_i) begin
         col_d = '0;
         row_d = '0;
      end else if (en_i) begin
         if (col_q == COL_MAX) begin
            col_d = '0;
            row_d = (row_q == ROW_MAX) ? '0 : row_q + 1'b1;
         end else begin
            col_d = col_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         col_q <= '0;
         row_q <= '0;
      end else begin
         col_q <= col_d;
         row_q <= row_d;
      end
   end

   assign col_o     = col_q;
   assign row_o     = row_q;
   assign col_nxt_o = col_d;
   assign row_nxt_o = row_d;
   assign last_o    = (col_q == COL_MAX) && (row_q == ROW_MAX);

endmodule

// File: rtl/median_frame_ctrl.sv
// Frame sequencer for the KxK median datapath: gates the pixel stream, flags
// complete windows, counts medians to frame completion and watches the drain.
//
// state | meaning
// IDLE  | waiting for start_i; medians arriving here are errors
// RUN   | accepting pixels, counting medians
// DRAIN | all pixels taken, waiting for the remaining medians under watchdog
module median_frame_ctrl
   import median_ctrl_pkg::*;
#(
   parameter int ROWS    = 11,
   parameter int COLS    = 11,
   parameter int K       = 9,
   parameter int TIMEOUT = 64
) (
   input  logic                                        clk,
   input  logic                                        rst,
   input  logic                                        start_i,
   input  logic                                        pix_valid_i,
   output logic                                        pix_ready_o,
   output logic                                        win_valid_o,
   input  logic                                        med_valid_i,
   output logic [((ROWS > 1) ? $clog2(ROWS) : 1)-1:0]  out_row_o,
   output logic [((COLS > 1) ? $clog2(COLS) : 1)-1:0]  out_col_o,
   output logic                                        busy_o,
   output logic                                        frame_done_o,
   output logic                                        err_o
);
   localparam int RW        = (ROWS > 1) ? $clog2(ROWS) : 1;
   localparam int CW        = (COLS > 1) ? $clog2(COLS) : 1;
   localparam int OH        = ROWS - K + 1;
   localparam int OW        = COLS - K + 1;
   localparam int ORW       = (OH > 1) ? $clog2(OH) : 1;
   localparam int OCW       = (OW > 1) ? $clog2(OW) : 1;
   localparam int OUT_TOTAL = out_total(ROWS, COLS, K);
   localparam int NW        = $clog2(OUT_TOTAL + 1);
   localparam int WDW       = $clog2(TIMEOUT + 1);
   localparam int OFF       = win_off(K);

   localparam logic [RW-1:0]  WIN_ROW_MIN = RW'(K - 1);
   localparam logic [CW-1:0]  WIN_COL_MIN = CW'(K - 1);
   localparam logic [RW-1:0]  ROW_OFF     = RW'(OFF);
   localparam logic [CW-1:0]  COL_OFF     = CW'(OFF);
   localparam logic [NW-1:0]  CNT_LAST    = NW'(OUT_TOTAL - 1);
   localparam logic [WDW-1:0] WD_LAST     = WDW'(TIMEOUT - 1);

   state_e state_q, state_d;

   logic [CW-1:0]  in_col, in_col_nxt;
   logic [RW-1:0]  in_row, in_row_nxt;
   logic           in_last;
   logic [OCW-1:0] o_col, o_col_nxt;
   logic [ORW-1:0] o_row, o_row_nxt;
   logic           o_last;

   logic start_acc, pix_acc, med_acc, last_med, wd_expire;

   logic           win_valid_q, frame_done_q, err_q;
   logic [RW-1:0]  out_row_q;
   logic [CW-1:0]  out_col_q;
   logic [NW-1:0]  out_cnt_q;
   logic [WDW-1:0] wd_q;

   assign start_acc = (state_q == IDLE) && start_i;
   assign pix_acc   = (state_q == RUN) && pix_valid_i;
   assign med_acc   = (state_q != IDLE) && med_valid_i;
   assign last_med  = med_acc && (out_cnt_q == CNT_LAST);
   assign wd_expire = (state_q == DRAIN) && !med_valid_i && (wd_q == WD_LAST);

   raster_counter #(.W(COLS), .H(ROWS)) u_in_raster (
      .clk       (clk),
      .rst       (rst),
      .clr_i     (start_acc),
      .en_i      (pix_acc),
      .col_o     (in_col),
      .row_o     (in_row),
      .col_nxt_o (in_col_nxt),
      .row_nxt_o (in_row_nxt),
      .last_o    (in_last)
   );

   raster_counter #(.W(OW), .H(OH)) u_out_raster (
      .clk       (clk),
      .rst       (rst),
      .clr_i     (start_acc),
      .en_i      (med_acc),
      .col_o     (o_col),
      .row_o     (o_row),
      .col_nxt_o (o_col_nxt),
      .row_nxt_o (o_row_nxt),
      .last_o    (o_last)
   );

   logic unused_raster;
   assign unused_raster = ^{in_col_nxt, in_row_nxt, o_col, o_row, o_last};

   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // Frame completion outranks the RUN->DRAIN step when the datapath is fast.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start_i) state_d = RUN;
         RUN: begin
            if (last_med)                state_d = IDLE;
            else if (pix_acc && in_last) state_d = DRAIN;
         end
         DRAIN:   if (last_med || wd_expire) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      pix_ready_o = (state_q == RUN);
      busy_o      = (state_q != IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         win_valid_q  <= 1'b0;
         frame_done_q <= 1'b0;
         err_q        <= 1'b0;
         out_row_q    <= '0;
         out_col_q    <= '0;
         out_cnt_q    <= '0;
         wd_q         <= '0;
      end else begin
         win_valid_q  <= pix_acc && (in_row >= WIN_ROW_MIN) && (in_col >= WIN_COL_MIN);
         frame_done_q <= last_med;

         if (start_acc)    out_cnt_q <= '0;
         else if (med_acc) out_cnt_q <= out_cnt_q + 1'b1;

         if ((state_q != DRAIN) || med_valid_i) wd_q <= '0;
         else                                    wd_q <= wd_q + 1'b1;

         if (((state_q == IDLE) && med_valid_i) || wd_expire) err_q <= 1'b1;
         else if (start_acc)                                    err_q <= 1'b0;

         // Coordinates are pre-loaded so they are valid in the cycle the median arrives.
         if (start_acc) begin
            out_row_q <= ROW_OFF;
            out_col_q <= COL_OFF;
         end else if (med_acc) begin
            out_row_q <= RW'(o_row_nxt) + ROW_OFF;
            out_col_q <= CW'(o_col_nxt) + COL_OFF;
         end
      end
   end

   assign win_valid_o  = win_valid_q;
   assign frame_done_o = frame_done_q;
   assign err_o        = err_q;
   assign out_row_o    = out_row_q;
   assign out_col_o    = out_col_q;

endmodule

// File: tb/tb_median_frame_ctrl.sv
// Bench for median_frame_ctrl: frame-level reference model checked every
// cycle, plus literal expectations for windows, coordinates and timeouts.
module tb_median_frame_ctrl;
   localparam int ROWS    = 11;
   localparam int COLS    = 11;
   localparam int K       = 9;
   localparam int TIMEOUT = 64;
   localparam int OW      = COLS - K + 1;
   localparam int TOTAL   = (ROWS - K + 1) * OW;
   localparam int OFF     = (K - 1) / 2;
   localparam int NPIX    = ROWS * COLS;

   logic       clk = 1'b0;
   logic       rst, start_i, pix_valid_i, med_valid_i;
   logic       pix_ready_o, win_valid_o, busy_o, frame_done_o, err_o;
   logic [3:0] out_row_o, out_col_o;

   median_frame_ctrl #(.ROWS(ROWS), .COLS(COLS), .K(K), .TIMEOUT(TIMEOUT)) dut (
      .clk          (clk),
      .rst          (rst),
      .start_i      (start_i),
      .pix_valid_i  (pix_valid_i),
      .pix_ready_o  (pix_ready_o),
      .win_valid_o  (win_valid_o),
      .med_valid_i  (med_valid_i),
      .out_row_o    (out_row_o),
      .out_col_o    (out_col_o),
      .busy_o       (busy_o),
      .frame_done_o (frame_done_o),
      .err_o        (err_o)
   );

   initial forever #5 clk = ~clk;

   int n_chk  = 0;
   int n_pass = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask

   // Datapath stand-in: medians follow windows by 3 cycles, optionally dropping one.
   logic [3:0] dp_pipe   = '0;
   logic       dp_med    = 1'b0;
   logic       dp_w      = 1'b0;
   logic       stray_med = 1'b0;
   int         dp_seen   = 0;
   int         dp_drop   = 0;
   assign med_valid_i = dp_med | stray_med;

   initial forever begin
      @(posedge clk); #1;
      dp_w = win_valid_o;
      if (dp_w) begin
         dp_seen++;
         if (dp_seen == dp_drop) dp_w = 1'b0;
      end
      dp_pipe = {dp_pipe[2:0], dp_w};
      dp_med  = dp_pipe[3];
   end

   // Frame-level reference model: mode 0 idle, 1 taking pixels, 2 draining.
   int m_mode = 0, m_pix = 0, m_med = 0, m_gap = 0, m_was = 0;
   bit e_win = 1'b0, e_done = 1'b0, e_err = 1'b0, n_win = 1'b0, n_done = 1'b0;

   initial forever begin
      @(negedge clk);
      chk("pix_ready",  32'(pix_ready_o),  32'(m_mode == 1));
      chk("busy",       32'(busy_o),       32'(m_mode != 0));
      chk("win_valid",  32'(win_valid_o),  32'(e_win));
      chk("frame_done", 32'(frame_done_o), 32'(e_done));
      chk("err",        32'(err_o),        32'(e_err));
      if (m_mode != 0 && med_valid_i) begin
         chk("out_row", 32'(out_row_o), m_med / OW + OFF);
         chk("out_col", 32'(out_col_o), m_med % OW + OFF);
      end
      if (rst) begin
         m_mode = 0; m_pix = 0; m_med = 0; m_gap = 0;
         e_win = 0; e_done = 0; e_err = 0;
      end else begin
         m_was = m_mode; n_win = 0; n_done = 0;
         if (m_was == 0) begin
            if (start_i) begin
               m_mode = 1; m_pix = 0; m_med = 0; m_gap = 0; e_err = 0;
            end
            if (med_valid_i) e_err = 1;
         end else begin
            if (m_was == 1 && pix_valid_i) begin
               n_win = (m_pix / COLS >= K - 1) && (m_pix % COLS >= K - 1);
               m_pix++;
               if (m_pix == NPIX) begin
                  m_mode = 2; m_gap = 0;
               end
            end
            if (med_valid_i) begin
               m_med++; m_gap = 0;
               if (m_med == TOTAL) begin
                  n_done = 1; m_mode = 0;
               end
            end else if (m_was == 2) begin
               m_gap++;
               if (m_gap == TIMEOUT) begin
                  e_err = 1; m_mode = 0;
               end
            end
         end
         e_win = n_win; e_done = n_done;
      end
   end

   // Event logs for the literal checks.
   int cyc = 0, sent = 0, med_cnt = 0, done_cnt = 0, acc_cnt = 0;
   int med8_cyc = -1, err_cyc = -1;
   bit err_prev = 1'b0;
   int win_log[$];
   int row_log[$];
   int col_log[$];
   int exp_win[9] = '{96, 97, 98, 107, 108, 109, 118, 119, 120};

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   initial forever begin
      @(negedge clk);
      if (win_valid_o) win_log.push_back(sent - 1);
      if (med_valid_i && busy_o) begin
         med_cnt++;
         row_log.push_back(int'(out_row_o));
         col_log.push_back(int'(out_col_o));
         if (med_cnt == 8) med8_cyc = cyc;
      end
      if (frame_done_o) done_cnt++;
      if (err_o && !err_prev) err_cyc = cyc;
      err_prev = err_o;
      if (pix_valid_i && pix_ready_o) acc_cnt++;
   end

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic clr_logs();
      win_log.delete(); row_log.delete(); col_log.delete();
      sent = 0; med_cnt = 0; done_cnt = 0; acc_cnt = 0; dp_seen = 0;
      med8_cyc = -1; err_cyc = -1;
   endtask

   task automatic do_start();
      start_i = 1'b1;
      tick();
      start_i = 1'b0;
   endtask

   task automatic send_frame(input bit gapped, input int start_at);
      bit v;
      while (sent < NPIX) begin
         v = gapped ? 1'($urandom_range(0, 1)) : 1'b1;
         pix_valid_i = v;
         start_i = v && (sent == start_at);
         tick();
         if (v) sent++;
      end
      pix_valid_i = 1'b0;
      start_i = 1'b0;
   endtask

   task automatic wait_done(input string tag, input int budget);
      bit found = 1'b0;
      for (int i = 0; i < budget; i++) begin
         tick();
         if (frame_done_o) begin
            found = 1'b1;
            break;
         end
      end
      chk({tag, "_done_seen"}, 32'(found), 32'd1);
   endtask

   task automatic chk_frame(input string tag);
      chk({tag, "_win_count"}, win_log.size(), 9);
      if (win_log.size() == 9)
         for (int i = 0; i < 9; i++) chk({tag, "_win_pixel"}, win_log[i], exp_win[i]);
      chk({tag, "_med_count"}, row_log.size(), 9);
      if (row_log.size() == 9) begin
         chk({tag, "_first_row"}, row_log[0], 4);
         chk({tag, "_first_col"}, col_log[0], 4);
         chk({tag, "_last_row"},  row_log[8], 6);
         chk({tag, "_last_col"},  col_log[8], 6);
      end
      chk({tag, "_done_pulses"}, done_cnt, 1);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_pix_ready"},  32'(pix_ready_o),  0);
      chk({tag, "_win_valid"},  32'(win_valid_o),  0);
      chk({tag, "_busy"},       32'(busy_o),       0);
      chk({tag, "_frame_done"}, 32'(frame_done_o), 0);
      chk({tag, "_err"},        32'(err_o),        0);
      chk({tag, "_out_row"},    32'(out_row_o),    0);
      chk({tag, "_out_col"},    32'(out_col_o),    0);
   endtask

   initial begin
      bit found;
      rst = 1'b1; start_i = 1'b0; pix_valid_i = 1'b0;
      repeat (3) tick();
      rst = 1'b0;
      @(negedge clk);
      chk_all_zero("reset");

      // Nominal back-to-back frame.
      tick(); clr_logs(); do_start();
      @(negedge clk);
      chk("s1_ready_after_start", 32'(pix_ready_o), 1);
      tick(); send_frame(1'b0, -1);
      wait_done("s1", 100);
      @(negedge clk);
      chk("s1_busy_with_done", 32'(busy_o), 0);
      repeat (3) tick();
      chk_frame("s1");

      // Gapped input.
      clr_logs(); do_start(); send_frame(1'b1, -1);
      wait_done("s2", 100);
      repeat (3) tick();
      chk_frame("s2");

      // Start while busy, pixels during DRAIN and IDLE.
      clr_logs(); do_start(); send_frame(1'b0, 50);
      pix_valid_i = 1'b1;
      wait_done("s3", 100);
      repeat (4) tick();
      pix_valid_i = 1'b0;
      tick();
      chk("s3_accepted_pixels", acc_cnt, NPIX);
      chk_frame("s3");

      // Drain timeout with the 9th median dropped.
      clr_logs(); dp_drop = 9; do_start(); send_frame(1'b0, -1);
      found = 1'b0;
      for (int i = 0; i < 200; i++) begin
         tick();
         if (err_o) begin
            found = 1'b1;
            break;
         end
      end
      chk("s4_err_seen", 32'(found), 1);
      @(negedge clk);
      chk("s4_err_delay", err_cyc - med8_cyc, 65);
      chk("s4_med_count", med_cnt, 8);
      chk("s4_no_done", done_cnt, 0);
      chk("s4_idle", 32'(busy_o), 0);
      dp_drop = 0;
      tick(); do_start();
      @(negedge clk);
      chk("s4_err_cleared", 32'(err_o), 0);
      tick(); sent = 0; send_frame(1'b0, -1);
      wait_done("s4_recover", 100);
      repeat (3) tick();

      // Stray median in IDLE, then reset mid-frame.
      stray_med = 1'b1; tick(); stray_med = 1'b0;
      @(negedge clk);
      chk("s5_stray_err", 32'(err_o), 1);
      tick(); clr_logs(); do_start();
      for (int i = 0; i < 60; i++) begin
         pix_valid_i = 1'b1;
         tick();
      end
      rst = 1'b1; tick(); rst = 1'b0; pix_valid_i = 1'b0;
      @(negedge clk);
      chk_all_zero("s5_after_rst");
      repeat (5) tick();
      clr_logs(); do_start(); send_frame(1'b0, -1);
      wait_done("s5", 100);
      repeat (3) tick();
      chk_frame("s5");

      // Back-to-back frames: start in the frame_done cycle.
      clr_logs(); do_start(); send_frame(1'b0, -1);
      wait_done("s6a", 100);
      start_i = 1'b1; tick(); start_i = 1'b0;
      @(negedge clk);
      chk("s6_ready_b2b", 32'(pix_ready_o), 1);
      tick(); sent = 0; send_frame(1'b0, -1);
      wait_done("s6b", 100);
      repeat (3) tick();
      chk("s6_done_pulses", done_cnt, 2);
      chk("s6_win_count", win_log.size(), 18);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/median_frame_ctrl.md
# median_frame_ctrl

Frame-level sequencer for the 9x9 median filter datapath. Accepts a raster pixel stream of one ROWS x COLS frame, tracks input row/column, and asserts the datapath's window-valid strobe only for pixels that complete a full KxK window. Counts the datapath's median-valid strobes until every window of the frame has been produced, then pulses frame-done. It sits between the pixel source / line-buffer front end and the 9x9 median datapath, and supervises the pipeline drain with a watchdog.

## Interface
- ROWS, 11, frame height in pixels (must be >= K)
- COLS, 11, frame width in pixels (must be >= K)
- K, 9, window size (odd)
- TIMEOUT, 64, maximum idle cycles allowed in DRAIN between median outputs
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- start_i  in  1  one-cycle frame start request
- pix_valid_i  in  1  input pixel present on the stream
- pix_ready_o  out  1  controller accepts pixels (RUN only)
- win_valid_o  out  1  full KxK window is ready; drives the datapath done_i
- med_valid_i  in  1  datapath median-valid, from the datapath done_o
- out_row_o  out  $clog2(ROWS)  centre row of the median currently flagged by med_valid_i
- out_col_o  out  $clog2(COLS)  centre column of the same median
- busy_o  out  1  high in RUN and DRAIN
- frame_done_o  out  1  one-cycle pulse when the last median of the frame is counted
- err_o  out  1  sticky error flag, cleared by the next accepted start_i

## Operation
- **State IDLE**
  - start_i moves the FSM to RUN.
  - In the same cycle, clear the row, col and output counters and err_o.
- **State RUN**
  - pix_ready_o = 1. A pixel is accepted when pix_valid_i = 1.
  - Each accepted pixel advances col. col wraps COLS-1 -> 0 and increments row.
  - An accepted pixel with row >= K-1 and col >= K-1 schedules win_valid_o.
  - Acceptance of pixel (ROWS-1, COLS-1) moves the FSM to DRAIN.
- **State DRAIN**
  - pix_ready_o = 0. Pixels are ignored.
  - The watchdog counts cycles without med_valid_i and resets to 0 on each med_valid_i.
  - If the watchdog reaches TIMEOUT: set err_o and go to IDLE. No frame_done_o pulse.
- **Output counting (RUN and DRAIN)**
  - Each med_valid_i increments out_cnt. OUT_TOTAL = (ROWS-K+1)*(COLS-K+1).
  - When out_cnt reaches OUT_TOTAL: pulse frame_done_o and go to IDLE.
  - This completion can happen in RUN if the datapath latency is short. In that case go to IDLE directly.
- **out_row_o / out_col_o**
  - Track the output window origin (orow, ocol) in raster order over (ROWS-K+1) x (COLS-K+1).
  - Outputs are orow+(K-1)/2 and ocol+(K-1)/2, registered. They are valid whenever med_valid_i is high.
- **Ignored inputs and errors**
  - start_i while busy_o = 1 is ignored.
  - med_valid_i in IDLE sets err_o and is not counted.
- No backpressure toward the datapath. med_valid_i is counted every cycle it is high.

## Timing
- **Reset values:** all outputs are 0. The FSM is in IDLE and all counters are 0.
- rst mid-frame aborts immediately. The next cycle is IDLE with outputs 0. Any in-flight medians then flag err_o.
- **start_i latency:** asserting start_i in cycle t gives pix_ready_o = 1 in t+1.
- **win_valid_o latency:** it is registered, so it is high in cycle t+1 for a window-completing pixel accepted in cycle t. It is a one-cycle pulse per window and is never high in IDLE.
- **DRAIN entry:** the FSM is in DRAIN in the cycle after the last pixel is accepted, so pix_ready_o = 0 then.
- **frame_done_o latency:** the pulse comes in t+1 for the final med_valid_i in cycle t. busy_o = 0 in the same cycle.
- A new start_i is accepted in the cycle frame_done_o is high (the FSM is already in IDLE).
- **Simultaneous pixel acceptance and med_valid_i:** both are processed in the same cycle, with independent counters.
- **Counter widths:** row/col use $clog2 of the dimension. out_cnt uses $clog2(OUT_TOTAL+1). The watchdog uses $clog2(TIMEOUT+1). There is no overflow in legal operation.

## Structure
- **Shared package median_ctrl_pkg:**
  - state enum {IDLE, RUN, DRAIN}
  - a function computing OUT_TOTAL
  - the window-centre offset constant (K-1)/2
- **Sub-module raster_counter:** a parameterized (W, H) col/row counter with enable, wrap and last flag. Instantiate it twice: input raster and output-origin raster.
- The FSM, watchdog and error logic stay in the top.

## Test plan
All scenarios use ROWS = COLS = 11, K = 9, TIMEOUT = 64, so OUT_TOTAL = 9.
- **Nominal frame:** start, 121 back-to-back pixels, datapath model with 3-cycle latency.
  - win_valid_o pulses exactly 9 times, after pixel indices 96-98, 107-109 and 118-120.
  - The first med_valid_i reports out_row/out_col = (4,4), the last (6,6).
  - frame_done_o is a single pulse and busy_o falls with it.
- **Gapped input:** pix_valid_i random at 50% duty.
  - Same 9 win_valid_o pulses and the same coordinates.
  - pix_ready_o is high throughout RUN.
- **Start while busy and pixels while not ready:** start_i pulsed mid-RUN; pixels driven during DRAIN and IDLE.
  - Both are ignored and the counts stay 121 pixels / 9 windows.
- **Drain timeout:** the datapath model drops the 9th median.
  - err_o = 1 exactly 65 cycles after the 8th med_valid_i, FSM in IDLE, no frame_done_o.
  - The next start_i clears err_o.
- **Stray median and reset:** med_valid_i in IDLE sets err_o = 1. Then rst asserted at pixel 60 mid-frame.
  - The next cycle has all outputs 0.
  - A following full frame completes normally.
- **Back-to-back frames:** start_i asserted in the frame_done_o cycle.
  - The second frame runs with pix_ready_o = 1 on the next cycle and produces a second, correct frame_done_o.
